// File: rtl/signal_generator_multi.sv
// Multi-waveform tone generator (triangle/saw/square/sine) with glitch-free settings update at period wrap.
// Latency: outputSample is 1 cycle behind phase. No backpressure: free-running at the CLK_32KHz sample rate.
module signal_generator_multi #(
    parameter int SAMPLE_W    = 8,
    parameter int IDX_W       = 7,
    parameter int FREQ_W      = 14,
    parameter int SAMPLE_RATE = 32000,
    parameter int FREQ_MAX    = 8000
) (
    input  logic                CLK_32KHz,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                load,
    input  logic [FREQ_W-1:0]   freq_in,
    input  logic [1:0]          wave_sel,
    input  logic [SAMPLE_W-1:0] amplitude,
    output logic [SAMPLE_W-1:0] outputSample,
    output logic                wrap,
    output logic                pending
);
    localparam int PH_W  = $clog2(SAMPLE_RATE + FREQ_MAX);
    localparam int DEPTH = 2 ** IDX_W;
    localparam int S     = SAMPLE_W - IDX_W;
    localparam int H     = 2 ** (IDX_W - 1);

    localparam logic [PH_W-1:0]       SR_V       = PH_W'(SAMPLE_RATE);
    localparam logic [PH_W+IDX_W-1:0] SR_X       = (PH_W + IDX_W)'(SAMPLE_RATE);
    localparam logic [FREQ_W-1:0]     FREQ_MAX_V = FREQ_W'(FREQ_MAX);
    localparam logic [1:0]            WAVE_TRI   = 2'd0;
    localparam logic [1:0]            WAVE_SAW   = 2'd1;
    localparam logic [1:0]            WAVE_SQR   = 2'd2;

    typedef logic [DEPTH-1:0][SAMPLE_W-1:0] rom_t;

    function automatic rom_t build_sine();
        rom_t r;
        real  half;
        real  v;
        half = real'(2 ** SAMPLE_W - 1) / 2.0;
        for (int k = 0; k < DEPTH; k++) begin
            v    = half * (1.0 + $sin(2.0 * 3.14159265358979 * real'(k) / real'(DEPTH)));
            r[k] = SAMPLE_W'($rtoi(v + 0.5));
        end
        return r;
    endfunction

    localparam rom_t SINE_ROM = build_sine();

    logic [PH_W-1:0]     phase_q, phase_d;
    logic [FREQ_W-1:0]   freq_act_q, freq_act_d, freq_pend_q, freq_pend_d;
    logic [1:0]          wave_act_q, wave_act_d, wave_pend_q, wave_pend_d;
    logic [SAMPLE_W-1:0] amp_act_q, amp_act_d, amp_pend_q, amp_pend_d;
    logic                pending_q, pending_d;
    logic                wrap_q, wrap_d;
    logic [SAMPLE_W-1:0] out_q, out_d;

    logic [PH_W-1:0]     sum;
    logic                wrap_cyc;
    logic [FREQ_W-1:0]   freq_clamped;
    logic [IDX_W-1:0]    idx;
    logic [31:0]         tri_w;
    logic [SAMPLE_W-1:0] raw;
    logic [SAMPLE_W-1:0] scaled;

    assign sum          = phase_q + PH_W'(freq_act_q);
    assign wrap_cyc     = (sum >= SR_V);
    assign freq_clamped = (freq_in > FREQ_MAX_V) ? FREQ_MAX_V : freq_in;
    // Exact floor(phase * 2^IDX_W / SAMPLE_RATE); divisor is a constant.
    assign idx          = IDX_W'({phase_q, {IDX_W{1'b0}}} / SR_X);

    always_comb begin
        tri_w = 32'd0;
        raw   = '0;
        if (32'(idx) < 32'(H)) begin
            tri_w = (32'(idx) << 1) << S;
        end else if (32'(idx) > 32'(H)) begin
            tri_w = ((32'd2 ** (IDX_W + 1)) - (32'(idx) << 1)) << S;
        end
        case (wave_act_q)
            WAVE_TRI: raw = (32'(idx) == 32'(H)) ? '1 : SAMPLE_W'(tri_w);
            WAVE_SAW: raw = SAMPLE_W'(idx) << S;
            WAVE_SQR: raw = (32'(idx) < 32'(H)) ? '1 : '0;
            default:  raw = SINE_ROM[idx];
        endcase
    end

    assign scaled = SAMPLE_W'(((2 * SAMPLE_W + 1)'(raw)
                    * (2 * SAMPLE_W + 1)'({1'b0, amp_act_q} + 1'b1)) >> SAMPLE_W);

    always_comb begin
        phase_d     = phase_q;
        wrap_d      = 1'b0;
        out_d       = '0;
        freq_act_d  = freq_act_q;
        wave_act_d  = wave_act_q;
        amp_act_d   = amp_act_q;
        freq_pend_d = freq_pend_q;
        wave_pend_d = wave_pend_q;
        amp_pend_d  = amp_pend_q;
        pending_d   = pending_q;
        if (!enable) begin
            // Stopped: nothing audible can glitch, so settings apply at once.
            phase_d   = '0;
            pending_d = 1'b0;
            if (load) begin
                freq_act_d = freq_clamped;
                wave_act_d = wave_sel;
                amp_act_d  = amplitude;
            end else if (pending_q) begin
                freq_act_d = freq_pend_q;
                wave_act_d = wave_pend_q;
                amp_act_d  = amp_pend_q;
            end
        end else begin
            phase_d = wrap_cyc ? (sum - SR_V) : sum;
            wrap_d  = wrap_cyc;
            out_d   = scaled;
            if (load && wrap_cyc) begin
                freq_act_d = freq_clamped;
                wave_act_d = wave_sel;
                amp_act_d  = amplitude;
                pending_d  = 1'b0;
            end else if (load) begin
                freq_pend_d = freq_clamped;
                wave_pend_d = wave_sel;
                amp_pend_d  = amplitude;
                pending_d   = 1'b1;
            end else if (wrap_cyc && pending_q) begin
                freq_act_d = freq_pend_q;
                wave_act_d = wave_pend_q;
                amp_act_d  = amp_pend_q;
                pending_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            phase_q     <= '0;
            wrap_q      <= 1'b0;
            out_q       <= '0;
            freq_act_q  <= '0;
            wave_act_q  <= '0;
            amp_act_q   <= '1;
            freq_pend_q <= '0;
            wave_pend_q <= '0;
            amp_pend_q  <= '0;
            pending_q   <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            wrap_q      <= wrap_d;
            out_q       <= out_d;
            freq_act_q  <= freq_act_d;
            wave_act_q  <= wave_act_d;
            amp_act_q   <= amp_act_d;
            freq_pend_q <= freq_pend_d;
            wave_pend_q <= wave_pend_d;
            amp_pend_q  <= amp_pend_d;
            pending_q   <= pending_d;
        end
    end

    assign outputSample = out_q;
    assign wrap         = wrap_q;
    assign pending      = pending_q;
endmodule

// File: tb/tb_signal_generator_multi.sv
// Directed bench for signal_generator_multi at default parameters (8-bit samples, 128-entry period, 32 kHz).
module tb_signal_generator_multi;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        load;
    logic [13:0] freq_in;
    logic [1:0]  wave_sel;
    logic [7:0]  amplitude;
    logic [7:0]  outputSample;
    logic        wrap;
    logic        pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    signal_generator_multi dut (
        .CLK_32KHz    (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .load         (load),
        .freq_in      (freq_in),
        .wave_sel     (wave_sel),
        .amplitude    (amplitude),
        .outputSample (outputSample),
        .wrap         (wrap),
        .pending      (pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Triangle at unity gain for index n: 0,4,...,252,255,252,...,4
    function automatic int tri_ref(input int n);
        if (n < 64) return 4 * n;
        if (n == 64) return 255;
        return 512 - 4 * n;
    endfunction

    task automatic load_disabled(input int f, input int w, input int a);
        enable    = 1'b0;
        load      = 1'b1;
        freq_in   = 14'(f);
        wave_sel  = 2'(w);
        amplitude = 8'(a);
        tick();
        load = 1'b0;
        check("load_dis_pending", 32'(pending), 32'd0);
        check("load_dis_out", 32'(outputSample), 32'd0);
        check("load_dis_wrap", 32'(wrap), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        load      = 1'b0;
        freq_in   = '0;
        wave_sel  = '0;
        amplitude = 8'hFF;
        #2;
        check("rst_out", 32'(outputSample), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        #20;
        reset_n = 1'b1;
        tick();

        // Triangle 250 Hz: two full periods
        load_disabled(250, 0, 255);
        enable = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            tick();
            check($sformatf("tri_out_%0d", k), 32'(outputSample), 32'(tri_ref((k - 1) % 128)));
            check($sformatf("tri_wrap_%0d", k), 32'(wrap), (k % 128 == 0) ? 32'd1 : 32'd0);
        end

        // Mid-period switch to sine at phase 10000
        repeat (40) tick();
        load     = 1'b1;
        wave_sel = 2'd3;
        freq_in  = 14'd250;
        tick();
        load = 1'b0;
        check("mid_pending_rise", 32'(pending), 32'd1);
        check("mid_out_41", 32'(outputSample), 32'd160);
        for (int k = 42; k <= 127; k++) begin
            tick();
            check($sformatf("mid_tri_%0d", k), 32'(outputSample), 32'(tri_ref(k - 1)));
            check($sformatf("mid_pend_%0d", k), 32'(pending), 32'd1);
        end
        tick();
        check("mid_wrap", 32'(wrap), 32'd1);
        check("mid_pending_fall", 32'(pending), 32'd0);
        check("mid_last_tri", 32'(outputSample), 32'd4);
        tick();
        check("sine_i0", 32'(outputSample), 32'd128);
        tick();
        check("sine_i1", 32'(outputSample), 32'd134);
        repeat (31) tick();
        check("sine_i32", 32'(outputSample), 32'd255);

        // Sawtooth 1000 Hz
        load_disabled(1000, 1, 255);
        enable = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            tick();
            check($sformatf("saw_out_%0d", k), 32'(outputSample), 32'(8 * ((k - 1) % 32)));
            check($sformatf("saw_wrap_%0d", k), 32'(wrap), (k % 32 == 0) ? 32'd1 : 32'd0);
        end

        // Square at 9000 Hz requested, clamped to 8000 Hz
        load_disabled(9000, 2, 255);
        enable = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            check($sformatf("sqr_out_%0d", k), 32'(outputSample), ((k - 1) % 4 < 2) ? 32'd255 : 32'd0);
            check($sformatf("sqr_wrap_%0d", k), 32'(wrap), (k % 4 == 0) ? 32'd1 : 32'd0);
        end

        // Amplitude 127 on triangle 250 Hz
        load_disabled(250, 0, 127);
        enable = 1'b1;
        for (int k = 1; k <= 128; k++) begin
            tick();
            check($sformatf("amp_out_%0d", k), 32'(outputSample), 32'((tri_ref(k - 1) * 128) >> 8));
            if (k == 2) check("amp_i1", 32'(outputSample), 32'd2);
            if (k == 65) check("amp_peak", 32'(outputSample), 32'd127);
        end

        // Asynchronous reset mid-period with a load pending
        repeat (10) tick();
        load     = 1'b1;
        freq_in  = 14'd1000;
        wave_sel = 2'd1;
        tick();
        load = 1'b0;
        check("pre_rst_pending", 32'(pending), 32'd1);
        check("pre_rst_out", 32'(outputSample), 32'((tri_ref(10) * 128) >> 8));
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_out", 32'(outputSample), 32'd0);
        check("async_rst_wrap", 32'(wrap), 32'd0);
        check("async_rst_pending", 32'(pending), 32'd0);
        #3;
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("post_rst_out_%0d", k), 32'(outputSample), 32'd0);
            check($sformatf("post_rst_wrap_%0d", k), 32'(wrap), 32'd0);
            check($sformatf("post_rst_pend_%0d", k), 32'(pending), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
